// File: rtl/hazard_sched.sv
// Hazard controller for the 5-stage core: load-use / branch-operand / MDU stalls, IF/ID and ID/EX flushes,
// fixed-latency MDU issue tracking and a saturating stall-cycle counter.
module hazard_sched #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             BranchD,
  input  logic             JumpRegD,
  input  logic             BranchTakenD,
  input  logic             MdOpD,
  input  logic             MdReadD,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [4:0]       WriteRegM,
  input  logic             MemtoRegM,
  output logic             StaIF,
  output logic             StaID,
  output logic             FlushID,
  output logic             FlushE,
  output logic             MdStartE,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  localparam logic [7:0]       MD_INIT = 8'(MD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  md_state_e        state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             md_start_q, md_start_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lwstall, brstall, mdstall, stall;
  logic ex_fwd_rs, ex_fwd_rt, mem_ld_rs, mem_ld_rt;
  logic br_rs_haz, br_rt_haz;
  logic issue;

  assign MdBusy = (state_q == BUSY);

  always_comb begin
    lwstall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));

    // Operands compared in ID must not be in flight from an ALU op in EX or a load in MEM.
    ex_fwd_rs = RegWriteE && (WriteRegE != 5'd0) && (WriteRegE == RsD);
    ex_fwd_rt = RegWriteE && (WriteRegE != 5'd0) && (WriteRegE == RtD);
    mem_ld_rs = MemtoRegM && (WriteRegM != 5'd0) && (WriteRegM == RsD);
    mem_ld_rt = MemtoRegM && (WriteRegM != 5'd0) && (WriteRegM == RtD);
    br_rs_haz = (BranchD || JumpRegD) && (ex_fwd_rs || mem_ld_rs);
    br_rt_haz = BranchD && (ex_fwd_rt || mem_ld_rt);
    brstall   = br_rs_haz || br_rt_haz;

    mdstall = (MdOpD || MdReadD) && MdBusy;
    stall   = lwstall || brstall || mdstall;
  end

  always_comb begin
    StaIF   = ~RST && stall;
    StaID   = ~RST && stall;
    FlushE  = RST || stall;
    FlushID = RST || (BranchTakenD && ~stall);
  end

  always_comb begin
    issue       = MdOpD && ~stall;
    state_d     = state_q;
    cnt_d       = cnt_q;
    md_start_d  = 1'b0;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d    = BUSY;
          cnt_d      = MD_INIT;
          md_start_d = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      md_start_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_start_q  <= md_start_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MdStartE   = md_start_q;
  assign StallCount = stall_cnt_q;

endmodule
